// File: rtl/cam_pkg.sv
// Shared types and default sizing for the CAM match-vector scan logic.
package cam_pkg;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_BUSY = 1'b1
  } scan_state_e;

  localparam int CAM_DEPTH = 128;
  localparam int CAM_IDX_W = $clog2(CAM_DEPTH);

endpackage

// File: rtl/prienc_lsb.sv
// LSB-first priority encoder: index of the lowest set bit, zero when the vector is empty.
module prienc_lsb #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = $clog2(IN_WIDTH)
) (
  input  logic [IN_WIDTH-1:0]  vec_i,
  output logic [OUT_WIDTH-1:0] idx_o
);

  logic [OUT_WIDTH-1:0] idx_s;

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    idx_s = '0;
    for (int i = IN_WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_s = OUT_WIDTH'(i);
      end else begin
        idx_s = idx_s;
      end
    end
  end

  assign idx_o = idx_s;

endmodule

// File: rtl/cam_match_scan.sv
// Turns one CAM match vector into a handshaked stream of matching indices, lowest first.
module cam_match_scan
  import cam_pkg::*;
#(
  parameter int IN_WIDTH  = CAM_DEPTH,
  parameter int OUT_WIDTH = $clog2(IN_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 match_vld_i,
  output logic                 match_rdy_o,
  input  logic [IN_WIDTH-1:0]  match_vec_i,
  input  logic                 abort_i,
  output logic                 idx_vld_o,
  input  logic                 idx_rdy_i,
  output logic [OUT_WIDTH-1:0] idx_o,
  output logic                 idx_last_o,
  output logic                 miss_o,
  output logic                 busy_o,
  output logic [OUT_WIDTH:0]   hit_cnt_o
);

  scan_state_e          state_q, state_d;
  logic [IN_WIDTH-1:0]  pend_q, pend_d;
  logic [OUT_WIDTH:0]   cnt_q, cnt_d;
  logic                 rdy_q, rdy_d;
  logic                 vld_q, vld_d;
  logic                 busy_q, busy_d;
  logic                 miss_q, miss_d;

  logic [IN_WIDTH-1:0]  pend_clr_s;
  logic                 last_s;
  logic [OUT_WIDTH-1:0] idx_enc_s;

  assign pend_clr_s = pend_q & (pend_q - IN_WIDTH'(1));
  assign last_s     = (pend_clr_s == '0);

  prienc_lsb #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_prienc (
    .vec_i (pend_q),
    .idx_o (idx_enc_s)
  );

  // Next-state logic; abort outranks both acceptance and index transfer.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    miss_d  = 1'b0;
    case (state_q)
      SCAN_IDLE: begin
        if (abort_i) begin
          pend_d = pend_q;
        end else if (match_vld_i) begin
          pend_d = match_vec_i;
          cnt_d  = '0;
          if (match_vec_i != '0) begin
            state_d = SCAN_BUSY;
          end else begin
            miss_d = 1'b1;
          end
        end else begin
          pend_d = pend_q;
        end
      end
      SCAN_BUSY: begin
        if (abort_i) begin
          pend_d  = '0;
          state_d = SCAN_IDLE;
        end else if (idx_rdy_i) begin
          pend_d = pend_clr_s;
          cnt_d  = cnt_q + (OUT_WIDTH + 1)'(1);
          if (last_s) begin
            state_d = SCAN_IDLE;
          end else begin
            state_d = SCAN_BUSY;
          end
        end else begin
          pend_d = pend_q;
        end
      end
      default: begin
        state_d = SCAN_IDLE;
        pend_d  = '0;
      end
    endcase
    rdy_d  = (state_d == SCAN_IDLE);
    vld_d  = (state_d == SCAN_BUSY);
    busy_d = (state_d == SCAN_BUSY);
  end

  // State, pending vector and all handshake/status outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN_IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      miss_q  <= miss_d;
    end
  end

  assign match_rdy_o = rdy_q;
  assign idx_vld_o   = vld_q;
  assign busy_o      = busy_q;
  assign miss_o      = miss_q;
  assign hit_cnt_o   = cnt_q;
  assign idx_o       = idx_enc_s;
  // pend is zero outside a scan, so gate last with valid to keep it low in IDLE.
  assign idx_last_o  = vld_q & last_s;

endmodule

// File: tb/tb_cam_match_scan.sv
// Randomized bench for cam_match_scan against a queue-based reference model.
module tb_cam_match_scan;

  localparam int W  = 128;
  localparam int OW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          match_vld_i = 1'b0;
  logic          match_rdy_o;
  logic [W-1:0]  match_vec_i = '0;
  logic          abort_i = 1'b0;
  logic          idx_vld_o;
  logic          idx_rdy_i = 1'b0;
  logic [OW-1:0] idx_o;
  logic          idx_last_o;
  logic          miss_o;
  logic          busy_o;
  logic [OW:0]   hit_cnt_o;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: pending indices as a queue, plus scan flag, count and miss pulse.
  int exp_q[$];
  bit m_busy = 1'b0;
  int m_cnt  = 0;
  bit m_miss = 1'b0;

  cam_match_scan #(.IN_WIDTH(W), .OUT_WIDTH(OW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .match_vld_i (match_vld_i),
    .match_rdy_o (match_rdy_o),
    .match_vec_i (match_vec_i),
    .abort_i     (abort_i),
    .idx_vld_o   (idx_vld_o),
    .idx_rdy_i   (idx_rdy_i),
    .idx_o       (idx_o),
    .idx_last_o  (idx_last_o),
    .miss_o      (miss_o),
    .busy_o      (busy_o),
    .hit_cnt_o   (hit_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("match_rdy", 32'(match_rdy_o), 32'(!m_busy));
    check("idx_vld",   32'(idx_vld_o),   32'(m_busy));
    check("busy",      32'(busy_o),      32'(m_busy));
    check("miss",      32'(miss_o),      32'(m_miss));
    check("hit_cnt",   32'(hit_cnt_o),   32'(m_cnt));
    check("idx_last",  32'(idx_last_o),  32'(m_busy && exp_q.size() == 1));
    if (m_busy) begin
      check("idx", 32'(idx_o), 32'(exp_q[0]));
    end
  endtask

  task automatic check_reset_values();
    check("rst_rdy",   32'(match_rdy_o), 32'd1);
    check("rst_vld",   32'(idx_vld_o),   32'd0);
    check("rst_idx",   32'(idx_o),       32'd0);
    check("rst_last",  32'(idx_last_o),  32'd0);
    check("rst_miss",  32'(miss_o),      32'd0);
    check("rst_busy",  32'(busy_o),      32'd0);
    check("rst_cnt",   32'(hit_cnt_o),   32'd0);
  endtask

  // One clock: check outputs, drive inputs, advance, then apply the model's rules.
  task automatic step(input bit vld, input logic [W-1:0] vec, input bit rdy, input bit ab);
    check_outputs();
    match_vld_i = vld;
    match_vec_i = vec;
    idx_rdy_i   = rdy;
    abort_i     = ab;
    @(posedge clk);
    #1;
    m_miss = 1'b0;
    if (m_busy) begin
      if (ab) begin
        exp_q.delete();
        m_busy = 1'b0;
      end else if (rdy) begin
        void'(exp_q.pop_front());
        m_cnt++;
        if (exp_q.size() == 0) m_busy = 1'b0;
      end
    end else if (vld && !ab) begin
      m_cnt = 0;
      exp_q.delete();
      for (int i = 0; i < W; i++) begin
        if (vec[i]) exp_q.push_back(i);
      end
      if (exp_q.size() == 0) m_miss = 1'b1;
      else m_busy = 1'b1;
    end
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  function automatic logic [W-1:0] rand_vec(input int mode);
    logic [W-1:0] v;
    logic [W-1:0] a;
    v = {$urandom, $urandom, $urandom, $urandom};
    case (mode)
      0: v = '0;
      1: begin
        v = '0;
        v[$urandom_range(0, W-1)] = 1'b1;
      end
      2: begin
        for (int k = 0; k < 2; k++) begin
          a = {$urandom, $urandom, $urandom, $urandom};
          v = v & a;
        end
      end
      default: begin
        for (int k = 0; k < 4; k++) begin
          a = {$urandom, $urandom, $urandom, $urandom};
          v = v & a;
        end
      end
    endcase
    return v;
  endfunction

  initial begin
    logic [W-1:0] v;

    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Sparse vector: bits 0, 2, 15.
    v = '0;
    v[0] = 1'b1; v[2] = 1'b1; v[15] = 1'b1;
    step(1'b1, v, 1'b1, 1'b0);
    idle_steps(5);

    // Back-to-back all-zero vectors.
    step(1'b1, '0, 1'b1, 1'b0);
    step(1'b1, '0, 1'b1, 1'b0);
    idle_steps(2);

    // Full vector with random backpressure.
    step(1'b1, '1, 1'b0, 1'b0);
    for (int k = 0; k < 1000 && m_busy; k++) begin
      step(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0);
    end
    check("full_done", 32'(m_busy), 32'd0);
    idle_steps(2);

    // Single bit at the top entry.
    v = '0;
    v[W-1] = 1'b1;
    step(1'b1, v, 1'b1, 1'b0);
    idle_steps(2);

    // Abort in the cycle index 2 transfers, vector {0, 2, 5}.
    v = '0;
    v[0] = 1'b1; v[2] = 1'b1; v[5] = 1'b1;
    step(1'b1, v, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("abort_idx", 32'(idx_o), 32'd2);
    step(1'b0, '0, 1'b1, 1'b1);
    check("abort_cnt", 32'(hit_cnt_o), 32'd1);
    idle_steps(3);

    // Reset asserted mid-scan, then a fresh scan from index 0.
    v = '1;
    step(1'b1, v, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    match_vld_i = 1'b0;
    idx_rdy_i = 1'b0;
    abort_i = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    m_busy = 1'b0;
    m_cnt = 0;
    m_miss = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v = '0;
    v[0] = 1'b1; v[9] = 1'b1;
    step(1'b1, v, 1'b1, 1'b0);
    check("post_rst_idx", 32'(idx_o), 32'd0);
    idle_steps(3);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      step(1'($urandom_range(0, 1)), rand_vec($urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));
    end
    for (int k = 0; k < 300 && m_busy; k++) begin
      step(1'b0, '0, 1'b1, 1'b0);
    end
    idle_steps(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
